// File: rtl/kb_pkg.sv
// Shared constants and the scan-code decode function for the keyboard command path.
// Command codes, PS/2 set-2 scan codes and the decoder FSM states live here.
package kb_pkg;

    localparam logic [2:0] CMD_UP      = 3'd0;
    localparam logic [2:0] CMD_DOWN    = 3'd1;
    localparam logic [2:0] CMD_LEFT    = 3'd2;
    localparam logic [2:0] CMD_RIGHT   = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_R     = 8'h2D;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DECODE
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] cmd;
    } decode_t;

    // kp[7:0] is the released key, kp[15:8] must be the break prefix,
    // kp[23:16] selects the extended (arrow) table. kp[31:24] is history only.
    function automatic decode_t decode_key(input logic [31:0] kp);
        decode_t res;
        res.hit = 1'b0;
        res.cmd = CMD_UP;
        if (kp[15:8] == SC_BREAK) begin
            if (kp[23:16] == SC_EXT) begin
                case (kp[7:0])
                    SC_UP:    begin res.hit = 1'b1; res.cmd = CMD_UP;    end
                    SC_DOWN:  begin res.hit = 1'b1; res.cmd = CMD_DOWN;  end
                    SC_LEFT:  begin res.hit = 1'b1; res.cmd = CMD_LEFT;  end
                    SC_RIGHT: begin res.hit = 1'b1; res.cmd = CMD_RIGHT; end
                    default:  ;
                endcase
            end else begin
                case (kp[7:0])
                    SC_W:    begin res.hit = 1'b1; res.cmd = CMD_UP;      end
                    SC_S:    begin res.hit = 1'b1; res.cmd = CMD_DOWN;    end
                    SC_A:    begin res.hit = 1'b1; res.cmd = CMD_LEFT;    end
                    SC_D:    begin res.hit = 1'b1; res.cmd = CMD_RIGHT;   end
                    SC_R:    begin res.hit = 1'b1; res.cmd = CMD_RESTART; end
                    default: ;
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/key_cmd_decoder.sv
// Turns PS/2 key-release events into single-cycle 2048 move commands
// presented over a registered valid/ready handshake with a sticky overflow flag.
module key_cmd_decoder #(
    parameter int unsigned SETTLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] keypress,
    input  logic        newVal,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        overflow
);

    import kb_pkg::*;

    localparam logic [15:0] CNT_LAST = 16'(SETTLE_CYCLES - 1);

    logic        s2;
    logic        s3_reg;
    logic        fall;
    logic [31:0] kp1_reg;
    logic [31:0] kp2_reg;
    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    decode_t     dec;
    logic        cmd_load;
    logic [2:0]  cmd_reg, cmd_next;
    logic        cmd_valid_reg, cmd_valid_next;
    logic        overflow_reg, overflow_next;

    sync_2ff u_sync_newval (
        .clk (clk),
        .rst (rst),
        .d   (newVal),
        .q   (s2)
    );

    // Falling edge of the break flag marks the arrival of the released key byte.
    assign fall = s3_reg & ~s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_reg  <= 1'b0;
            kp1_reg <= '0;
            kp2_reg <= '0;
        end else begin
            s3_reg  <= s2;
            kp1_reg <= keypress;
            kp2_reg <= kp1_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DECODE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DECODE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign dec      = decode_key(kp2_reg);
    assign cmd_load = (state_reg == DECODE) && dec.hit;

    // A new command may replace the held one only on the edge it is being taken.
    always_comb begin
        cmd_next       = cmd_reg;
        cmd_valid_next = cmd_valid_reg;
        overflow_next  = overflow_reg;
        if (cmd_load) begin
            if (!cmd_valid_reg || cmd_ready) begin
                cmd_next       = dec.cmd;
                cmd_valid_next = 1'b1;
            end else begin
                overflow_next = 1'b1;
            end
        end else if (cmd_valid_reg && cmd_ready) begin
            cmd_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_reg       <= CMD_UP;
            cmd_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            cmd_reg       <= cmd_next;
            cmd_valid_reg <= cmd_valid_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign cmd       = cmd_reg;
    assign cmd_valid = cmd_valid_reg;
    assign overflow  = overflow_reg;

endmodule
